fifo_sync_ice40: RTL and testbench

//  Single-clock, first-word-fall-through FIFO built from SB_RAM256x16 tiles, with valid/ready on both sides.

---
 rtl/fifo_sync_ice40_if.sv | 30 +++
 rtl/fifo_sync_ice40.sv | 154 +++++++++++++++
 tb/tb_fifo_sync_ice40.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_ice40_if.sv
// Stream interface of the fifo_sync_ice40 buffer.
// Carries the write side (in_valid/in_ready/in_data), the read side
// (out_valid/out_ready/out_data) and the occupancy status (count,
// almost_full, almost_empty).
//   slave  : the FIFO side (drives in_ready, out_*, status)
//   master : the producer/consumer side (drives in_valid, in_data, out_ready)
interface fifo_sync_ice40_if #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned AddrWidth = 9
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DataWidth-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DataWidth-1:0] out_data;
    logic [AddrWidth:0]   count;
    logic                 almost_full;
    logic                 almost_empty;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, almost_full, almost_empty
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, almost_full, almost_empty
    );
endinterface

// File: rtl/fifo_sync_ice40.sv
// Single-clock first-word-fall-through FIFO on 256x16 RAM tiles.
// Words are split into 16-bit lanes (one tile per lane) and the depth is
// organised in 256-word banks. A one-entry head stage presents the oldest
// word on out_data with out_valid.
// Ports:
//   clk   : single clock, all state changes on posedge
//   reset : synchronous, active-high; discards contents (RAM not cleared)
//   bus   : fifo_sync_ice40_if.slave (valid/ready write and read sides,
//           count, almost_full, almost_empty)
module fifo_sync_ice40 #(
    parameter int unsigned DataWidth   = 8,
    parameter int unsigned DataDepth   = 512,
    parameter int unsigned AddrWidth   = 9,
    parameter int unsigned AlmostFull  = 504,
    parameter int unsigned AlmostEmpty = 8,
    parameter int unsigned Debug       = 0
) (
    input  logic               clk,
    input  logic               reset,
    fifo_sync_ice40_if.slave   bus
);
    localparam int unsigned Lanes    = (DataWidth + 15) / 16;
    localparam int unsigned LaneBits = Lanes * 16;
    localparam int unsigned Banks    = DataDepth / 256;
    localparam int unsigned BankBits = (AddrWidth > 8) ? AddrWidth - 8 : 1;
    localparam int unsigned PtrW     = AddrWidth + 1;

    typedef enum logic {
        ST_EMPTY,
        ST_HEAD
    } head_state_e;

    head_state_e          state_q, state_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]      count_q, count_d;
    logic [BankBits-1:0]  rd_bank_q, rd_bank_d;
    logic                 almost_full_q, almost_full_d;
    logic                 almost_empty_q, almost_empty_d;

    logic                 push, pop, fetch, ram_empty;
    logic [BankBits-1:0]  wr_bank, rd_bank;
    logic [LaneBits-1:0]  wdata_pad;
    logic [LaneBits-1:0]  head_word;
    logic [Banks*LaneBits-1:0] rdata_flat;

    assign bus.in_ready     = ~reset & (count_q != PtrW'(DataDepth));
    assign bus.out_valid    = (state_q == ST_HEAD);
    assign bus.count        = count_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // Extra pointer MSB distinguishes a completely full RAM region from an
    // empty one. Push is blocked at count==DataDepth, so a fetch never reads
    // the address being written on the same edge.
    assign ram_empty = (wr_ptr_q == rd_ptr_q);
    assign fetch     = ~ram_empty & ((state_q == ST_EMPTY) | pop);

    assign wr_bank   = BankBits'(wr_ptr_q[AddrWidth-1:0] >> 8);
    assign rd_bank   = BankBits'(rd_ptr_q[AddrWidth-1:0] >> 8);
    assign wdata_pad = LaneBits'(bus.in_data);

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        rd_bank_d      = rd_bank_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (fetch) begin
            rd_ptr_d  = rd_ptr_q + PtrW'(1);
            rd_bank_d = rd_bank;
            state_d   = ST_HEAD;
        end else if (pop) begin
            state_d = ST_EMPTY;
        end
        if (push && !pop) begin
            count_d = count_q + PtrW'(1);
        end else if (pop && !push) begin
            count_d = count_q - PtrW'(1);
        end
        almost_full_d  = (count_d >= PtrW'(AlmostFull));
        almost_empty_d = (count_d <= PtrW'(AlmostEmpty));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_EMPTY;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rd_bank_q      <= '0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            rd_bank_q      <= rd_bank_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    // One 256x16 tile per (bank, lane). Only the addressed bank sees its
    // write/read enable; read data holds while RE is low, so the head word
    // is stable while the consumer stalls.
    for (genvar b = 0; b < Banks; b++) begin : g_bank
        for (genvar l = 0; l < Lanes; l++) begin : g_lane
            logic [15:0] mem [256];
            logic [15:0] rdata_q;
            logic        we, re;
            logic [15:0] wdata;

            assign we    = push  && (wr_bank == BankBits'(b));
            assign re    = fetch && (rd_bank == BankBits'(b));
            assign wdata = wdata_pad[l*16 +: 16];

            if (Debug != 0) begin : g_generic
                always_ff @(posedge clk) begin
                    if (we) begin
                        mem[wr_ptr_q[7:0]] <= wdata;
                    end
                    if (re) begin
                        rdata_q <= mem[rd_ptr_q[7:0]];
                    end
                end
            end else begin : g_sb
                // SB_RAM256x16 MASK: a set bit keeps the stored bit. All bits
                // are written, so padding bits above DataWidth store 0.
                localparam logic [15:0] WMask = '0;
                always_ff @(posedge clk) begin
                    if (we) begin
                        mem[wr_ptr_q[7:0]] <= (mem[wr_ptr_q[7:0]] & WMask) | (wdata & ~WMask);
                    end
                    if (re) begin
                        rdata_q <= mem[rd_ptr_q[7:0]];
                    end
                end
            end

            assign rdata_flat[(b*Lanes + l)*16 +: 16] = rdata_q;
        end
    end

    assign head_word    = rdata_flat[rd_bank_q*LaneBits +: LaneBits];
    assign bus.out_data = head_word[DataWidth-1:0];
endmodule

// File: tb/tb_fifo_sync_ice40.sv
// Directed and randomised self-checking bench for fifo_sync_ice40
// (DataWidth=24, DataDepth=512) against a queue reference model.
module tb_fifo_sync_ice40;
    localparam int unsigned DW    = 24;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fifo_sync_ice40_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

    fifo_sync_ice40 #(
        .DataWidth  (DW),
        .DataDepth  (DEPTH),
        .AddrWidth  (AW),
        .AlmostFull (504),
        .AlmostEmpty(8),
        .Debug      (0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [DW-1:0] q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with the current inputs, checked against the queue model.
    task automatic step();
        bit            exp_rdy, do_push, do_pop;
        logic [DW-1:0] w;
        exp_rdy = (q.size() != DEPTH);
        check("in_ready", bus.in_ready, exp_rdy);
        do_push = bus.in_valid && exp_rdy;
        do_pop  = bus.out_valid && bus.out_ready;
        if (q.size() == 0) check("out_valid_empty", bus.out_valid, 0);
        if (do_pop && q.size() > 0) check("out_data", bus.out_data, q[0]);
        w = bus.in_data;
        tick();
        if (do_pop && q.size() > 0) void'(q.pop_front());
        if (do_push) q.push_back(w);
        check("count", bus.count, q.size());
        check("almost_full", bus.almost_full, q.size() >= 504);
        check("almost_empty", bus.almost_empty, q.size() <= 8);
    endtask

    initial begin
        int unsigned pushed;
        int unsigned cyc;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset for three cycles
        reset = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_count", bus.count, 0);
        check("rst_almost_empty", bus.almost_empty, 1);
        check("rst_almost_full", bus.almost_full, 0);
        check("rst_in_ready", bus.in_ready, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        // Single word latency: push at edge N, visible after edge N+1
        bus.in_valid  = 1'b1;
        bus.in_data   = 24'h0000A5;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("lat_n_out_valid", bus.out_valid, 0);
        check("lat_n_count", bus.count, 1);
        tick();
        check("lat_n1_out_valid", bus.out_valid, 1);
        check("lat_n1_out_data", bus.out_data, 24'h0000A5);
        check("lat_n1_count", bus.count, 1);
        tick();
        check("pop_count", bus.count, 0);
        check("pop_out_valid", bus.out_valid, 0);
        q.delete();

        // Fill 512 ramp words, no pops; then drain across the bank boundary
        bus.out_ready = 1'b0;
        for (int i = 0; i < 512; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(i);
            step();
        end
        bus.in_valid = 1'b0;
        check("full_in_ready", bus.in_ready, 0);
        check("full_count", bus.count, 512);
        check("full_almost_full", bus.almost_full, 1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 512; i++) begin
            check("drain_ramp", bus.out_data, DW'(i));
            step();
        end
        check("drained_count", bus.count, 0);

        // Refill, then 1000 cycles of push+pop with in_valid held high
        bus.out_ready = 1'b0;
        for (int i = 0; i < 512; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(32'h1000 + i);
            step();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (i == 0) check("full_no_push", bus.in_ready, 0);
            bus.in_data = DW'(32'h2000 + i);
            step();
        end
        bus.in_valid = 1'b0;
        cyc = 0;
        while (q.size() > 0 && cyc < 2000) begin
            step();
            cyc++;
        end
        check("wrap_drain_done", q.size(), 0);

        // Random valid/ready traffic for 10k words
        pushed = 0;
        cyc    = 0;
        while (pushed < 10000 && cyc < 60000) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_data   = DW'($urandom);
            if (bus.in_valid && q.size() != DEPTH) pushed++;
            step();
            cyc++;
        end
        check("rand_words", pushed, 10000);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 2000) begin
            step();
            cyc++;
        end
        check("rand_drain_count", bus.count, 0);

        // Reset mid-stream with 37 words held
        bus.out_ready = 1'b0;
        for (int i = 0; i < 37; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(32'h500 + i);
            step();
        end
        bus.in_valid = 1'b0;
        check("pre_rst_count", bus.count, 37);
        reset = 1'b1;
        tick();
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        reset = 1'b0;
        q.delete();
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 24'h00003C;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("after_rst_out_valid", bus.out_valid, 1);
        check("after_rst_out_data", bus.out_data, 24'h00003C);
        check("after_rst_count", bus.count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
